srl16: RTL and testbench

Addressable 16-bit shift register with a dynamically selected output tap. It is a portable replacement for the vendor SRL16 and SRL16_1 primitives. It serves as a programmable 1..16-cycle delay line inside the pad and I/O circuitry. A single parameterised block covers both clock polarities: rising edge (SRL16) and falling edge (SRL16_1).

---
 rtl/srl16.sv | 43 ++++
 tb/tb_srl16.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/srl16.sv
// Addressable 16-stage shift register with a combinational output tap.
// INVERT selects the active clock edge (0: rising, 1: falling).
module srl16 #(
   parameter logic [15:0] INIT   = 16'h0000,
   parameter bit          INVERT = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       D,
   input  logic [3:0] A,
   output logic       Q
);

   // Declaration initialiser provides the power-up contents without a clock edge.
   logic [15:0] data_q = INIT;
   logic [15:0] data_d;

   always_comb begin
      data_d = data_q;
      if (RST) begin
         data_d = INIT;
      end else begin
         data_d = {data_q[14:0], D};
      end
   end

   generate
      if (INVERT) begin : g_fall
         always_ff @(negedge CLK) begin
            data_q <= data_d;
         end
      end else begin : g_rise
         always_ff @(posedge CLK) begin
            data_q <= data_d;
         end
      end
   endgenerate

   always_comb begin
      Q = data_q[A];
   end

endmodule

// File: tb/tb_srl16.sv
// Directed self-checking bench for srl16: table-driven INIT/reset vectors
// plus hand-written delay-line, depth, reset-priority, polarity and tap sequences.
module tb_srl16;

   logic       clk = 1'b0;

   logic       rst0 = 1'b0, d0 = 1'b0;
   logic [3:0] a0 = 4'd0;
   logic       q0;

   logic       rst1 = 1'b0, d1 = 1'b0;
   logic [3:0] a1 = 4'd0;
   logic       q1;

   logic       rst2 = 1'b0, d2 = 1'b0;
   logic [3:0] a2 = 4'd0;
   logic       q2;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   srl16 #(.INIT(16'hA5C3), .INVERT(1'b0)) u_init (
      .CLK(clk), .RST(rst0), .D(d0), .A(a0), .Q(q0));
   srl16 #(.INIT(16'h0000), .INVERT(1'b0)) u_rise (
      .CLK(clk), .RST(rst1), .D(d1), .A(a1), .Q(q1));
   srl16 #(.INIT(16'h0000), .INVERT(1'b1)) u_fall (
      .CLK(clk), .RST(rst2), .D(d2), .A(a2), .Q(q2));

   typedef struct packed {
      bit       tick;
      bit       rst;
      bit       d;
      bit [3:0] a;
      bit       exp;
   } vec_t;

   vec_t tbl[24];

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic rise();
      clk = 1'b1;
      #5;
   endtask

   task automatic fall();
      clk = 1'b0;
      #5;
   endtask

   task automatic tick();
      rise();
      fall();
   endtask

   initial begin
      bit sweep_exp[15] = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

      tbl[0] = '{tick: 1, rst: 1, d: 0, a: 4'd0, exp: 1};
      tbl[1] = '{tick: 1, rst: 1, d: 1, a: 4'd0, exp: 1};
      for (int i = 0; i < 15; i++)
         tbl[2 + i] = '{tick: 0, rst: 0, d: 0, a: 4'(i + 1), exp: sweep_exp[i]};
      tbl[17] = '{tick: 1, rst: 0, d: 0, a: 4'd0,  exp: 0};
      tbl[18] = '{tick: 0, rst: 0, d: 0, a: 4'd1,  exp: 1};
      tbl[19] = '{tick: 0, rst: 0, d: 0, a: 4'd8,  exp: 1};
      tbl[20] = '{tick: 0, rst: 0, d: 0, a: 4'd15, exp: 0};
      tbl[21] = '{tick: 1, rst: 0, d: 1, a: 4'd2,  exp: 1};
      tbl[22] = '{tick: 0, rst: 0, d: 0, a: 4'd0,  exp: 1};
      tbl[23] = '{tick: 0, rst: 0, d: 0, a: 4'd3,  exp: 1};

      #5;
      check("powerup_init_q0", q0, 1'b1);
      a0 = 4'd2;
      #1;
      check("powerup_init_q2", q0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rst0 = tbl[i].rst;
         d0   = tbl[i].d;
         a0   = tbl[i].a;
         if (tbl[i].tick) tick();
         else #1;
         check($sformatf("table_%0d", i), q0, tbl[i].exp);
      end
      rst0 = 1'b0;

      // Delay line at A=5: single 1 appears after exactly 6 edges.
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      a1 = 4'd5;
      for (int n = 1; n <= 8; n++) begin
         d1 = (n == 1);
         tick();
         check($sformatf("delay_edge_%0d", n), q1, logic'(n == 6));
      end

      // Full depth: 16'h8001 shifted MSB-first.
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      for (int n = 15; n >= 0; n--) begin
         d1 = (n == 15) || (n == 0);
         tick();
      end
      d1 = 1'b0;
      a1 = 4'd15; #1; check("depth_a15", q1, 1'b1);
      a1 = 4'd0;  #1; check("depth_a0", q1, 1'b1);
      for (int k = 1; k <= 14; k++) begin
         a1 = 4'(k); #1;
         check($sformatf("depth_a%0d", k), q1, 1'b0);
      end
      tick();
      a1 = 4'd1;  #1; check("depth_shift_a1", q1, 1'b1);
      a1 = 4'd15; #1; check("depth_shift_a15", q1, 1'b0);
      a1 = 4'd0;  #1; check("depth_shift_a0", q1, 1'b0);

      // Reset wins over D on the same edge.
      a1 = 4'd0; d1 = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      check("prio_ones", q1, 1'b1);
      rst1 = 1'b1; tick();
      check("prio_reset", q1, 1'b0);
      rst1 = 1'b0; tick();
      check("prio_after", q1, 1'b1);

      // Async tap read on 16'h00FF.
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      d1 = 1'b1;
      for (int n = 0; n < 8; n++) tick();
      d1 = 1'b0;
      a1 = 4'd7; #1; check("tap_a7", q1, 1'b1);
      a1 = 4'd8; #1; check("tap_a8", q1, 1'b0);

      // Clock polarity: rising-edge vs falling-edge instances.
      rst1 = 1'b1; rst2 = 1'b1; tick(); rst1 = 1'b0; rst2 = 1'b0;
      a1 = 4'd0; a2 = 4'd0;
      d1 = 1'b1; d2 = 1'b1;
      rise();
      check("pol_rise_on_rise", q1, 1'b1);
      check("pol_fall_on_rise", q2, 1'b0);
      fall();
      check("pol_fall_on_fall", q2, 1'b1);
      d1 = 1'b0; d2 = 1'b0;
      rise();
      check("pol_fall_hold_rise", q2, 1'b1);
      check("pol_rise_clr", q1, 1'b0);
      d1 = 1'b1;
      fall();
      check("pol_rise_hold_fall", q1, 1'b0);
      check("pol_fall_clr", q2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
